// File: rtl/lb2apb.sv
// lb2apb: bridges a pulse-based local bus with one write slot and one read slot onto an APB4 requester.
// Writes take priority over reads, and a watchdog ends transfers whose completer never raises pready.
module lb2apb #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              wen,
    output logic              wready,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              ren,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              slverr,
    output logic              ovf,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic [STRB_W-1:0] pstrb,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t state, state_next;

    logic              w_full;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic [STRB_W-1:0] w_strb;
    logic              r_full;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  to_cnt;

    logic busy;
    logic w_accept;
    logic r_accept;
    logic done;
    logic timeout_hit;
    logic start;

    // Request acceptance, completion detection and the launch condition for a new transfer.
    always_comb begin
        busy        = (state != IDLE);
        w_accept    = wen && !w_full && !(busy && pwrite);
        r_accept    = ren && !r_full && !(busy && !pwrite);
        done        = (state == ACCESS) && pready;
        timeout_hit = (TIMEOUT > 0) && (state == ACCESS) && !pready && (to_cnt == TO_LAST);
        start       = (w_full || r_full) && ((state == IDLE) || done);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        psel       = 1'b0;
        penable    = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = SETUP;
            end
            SETUP: begin
                psel       = 1'b1;
                state_next = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (done) begin
                    state_next = start ? SETUP : IDLE;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Slots are never loaded and freed in the same cycle: a load needs an empty slot, a free a full one.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_full <= 1'b0;
            w_addr <= '0;
            w_data <= '0;
            w_strb <= '0;
            r_full <= 1'b0;
            r_addr <= '0;
        end else begin
            if (w_accept) begin
                w_full <= 1'b1;
                w_addr <= waddr;
                w_data <= wdata;
                w_strb <= wstrb;
            end else if (start && w_full) begin
                w_full <= 1'b0;
            end
            if (r_accept) begin
                r_full <= 1'b1;
                r_addr <= raddr;
            end else if (start && !w_full) begin
                r_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pwrite <= 1'b0;
            paddr  <= '0;
            pwdata <= '0;
            pstrb  <= '0;
        end else if (start) begin
            pwrite <= w_full;
            paddr  <= w_full ? w_addr : r_addr;
            pwdata <= w_full ? w_data : '0;
            pstrb  <= w_full ? w_strb : '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            to_cnt <= '0;
        end else if (state == SETUP) begin
            to_cnt <= '0;
        end else if ((state == ACCESS) && !pready) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // A watchdog expiry completes the transfer like a normal response, but always as an error with zero data.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wready <= 1'b0;
            rvalid <= 1'b0;
            slverr <= 1'b0;
            ovf    <= 1'b0;
            rdata  <= '0;
        end else begin
            wready <= 1'b0;
            rvalid <= 1'b0;
            slverr <= 1'b0;
            ovf    <= (wen && !w_accept) || (ren && !r_accept);
            if (done || timeout_hit) begin
                wready <= pwrite;
                rvalid <= !pwrite;
                slverr <= done ? pslverr : 1'b1;
                if (!pwrite) rdata <= done ? prdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_lb2apb.sv
// tb_lb2apb: randomized scoreboard bench for lb2apb with a timestamp-based transaction model.
// The bench plays the APB completer, scheduling pready from the model's predicted transfer windows.
module tb_lb2apb;

    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [15:0] waddr = '0, raddr = '0, paddr;
    logic [31:0] wdata = '0, rdata, pwdata, prdata = '0;
    logic [3:0]  wstrb = '0, pstrb;
    logic        wen = 1'b0, ren = 1'b0, pready = 1'b0, pslverr = 1'b0;
    logic        wready, rvalid, slverr, ovf, psel, penable, pwrite;

    always #5 clk = ~clk;

    lb2apb #(.ADDR_W(16), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rstn(rstn),
        .waddr(waddr), .wdata(wdata), .wstrb(wstrb), .wen(wen), .wready(wready),
        .raddr(raddr), .ren(ren), .rdata(rdata), .rvalid(rvalid),
        .slverr(slverr), .ovf(ovf),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    typedef struct {
        int          cyc;
        bit          w;
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } apb_t;

    typedef struct {
        int          s;
        int          cyc;
        bit          w;
        bit          err;
        logic [31:0] rdata;
    } cpl_t;

    apb_t apb_q[$];
    cpl_t cpl_q[$];
    int   ovf_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    // Model: pending slots plus the window [act_s, act_done] of the most recent transfer, in edge numbers.
    bit          w_pend = 1'b0, r_pend = 1'b0;
    logic [15:0] w_a = '0, r_a = '0;
    logic [31:0] w_d = '0;
    logic [3:0]  w_s = '0;
    bit          act = 1'b0, act_w = 1'b0, act_to = 1'b0, act_err = 1'b0;
    int          act_s = 0, act_done = 0;
    logic [31:0] act_rd = '0;
    int          f_waits = -1, f_err = -1;
    bit          f_data_en = 1'b0;
    logic [31:0] f_data = '0;
    logic [31:0] exp_rdata = '0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            failures = failures + 1;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // One clock of stimulus: the model decides drops, launches and the completer response for the coming edge.
    task automatic applyStimulus(input bit i_wen, input logic [15:0] i_waddr, input logic [31:0] i_wdata,
                                 input logic [3:0] i_wstrb, input bit i_ren, input logic [15:0] i_raddr);
        int   t, waits;
        bit   bus_busy, in_access, completing, w_acc, r_acc;
        apb_t a;
        cpl_t c;
        @(negedge clk);
        t          = cyc + 1;
        bus_busy   = act && (act_s < t) && (t <= act_done);
        in_access  = bus_busy && (t > act_s + 1);
        completing = bus_busy && (t == act_done) && !act_to;
        w_acc      = i_wen && !w_pend && !(bus_busy && act_w);
        r_acc      = i_ren && !r_pend && !(bus_busy && !act_w);
        if ((i_wen && !w_acc) || (i_ren && !r_acc)) ovf_q.push_back(t);
        if (completing) begin
            pready  = 1'b1;
            pslverr = act_err;
            prdata  = act_rd;
        end else if (in_access) begin
            pready  = 1'b0;
            pslverr = 1'($urandom_range(0, 1));
            prdata  = $urandom;
        end else begin
            pready  = 1'($urandom_range(0, 1));
            pslverr = 1'($urandom_range(0, 1));
            prdata  = $urandom;
        end
        if ((w_pend || r_pend) && (!bus_busy || completing)) begin
            act      = 1'b1;
            act_w    = w_pend;
            act_s    = t;
            waits    = (f_waits >= 0) ? f_waits : int'($urandom_range(0, 10));
            act_to   = (waits >= TIMEOUT);
            act_done = act_to ? t + 1 + TIMEOUT : t + 2 + waits;
            act_err  = act_to ? 1'b1 : ((f_err >= 0) ? (f_err == 1) : 1'($urandom_range(0, 1)));
            act_rd   = f_data_en ? f_data : $urandom;
            a.cyc    = t;
            a.w      = act_w;
            a.addr   = act_w ? w_a : r_a;
            a.data   = act_w ? w_d : 32'h0;
            a.strb   = act_w ? w_s : 4'h0;
            apb_q.push_back(a);
            c.s      = t;
            c.cyc    = act_done;
            c.w      = act_w;
            c.err    = act_err;
            c.rdata  = act_to ? 32'h0 : act_rd;
            cpl_q.push_back(c);
            if (act_w) w_pend = 1'b0;
            else       r_pend = 1'b0;
        end
        if (w_acc) begin
            w_pend = 1'b1;
            w_a    = i_waddr;
            w_d    = i_wdata;
            w_s    = i_wstrb;
        end
        if (r_acc) begin
            r_pend = 1'b1;
            r_a    = i_raddr;
        end
        wen   = i_wen;
        waddr = i_waddr;
        wdata = i_wdata;
        wstrb = i_wstrb;
        ren   = i_ren;
        raddr = i_raddr;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'($urandom), $urandom, 4'($urandom), 1'b0, 16'($urandom));
    endtask

    task automatic clear_model();
        w_pend = 1'b0;
        r_pend = 1'b0;
        act    = 1'b0;
        apb_q.delete();
        cpl_q.delete();
        ovf_q.delete();
        exp_rdata = '0;
    endtask

    // Monitor: pops expected completions, APB setups and overflow pulses as the DUT presents them.
    apb_t mon_cur;
    cpl_t mon_c;
    bit   exp_psel, exp_pen;
    always @(negedge clk) begin
        if (rstn && mon_en) begin
            exp_psel = 1'b0;
            exp_pen  = 1'b0;
            for (int k = 0; k < 2; k++) begin
                if (k < cpl_q.size()) begin
                    if (cpl_q[k].s <= cyc && cyc < cpl_q[k].cyc) exp_psel = 1'b1;
                    if (cpl_q[k].s < cyc && cyc < cpl_q[k].cyc) exp_pen = 1'b1;
                end
            end
            checkOutput("psel_penable", 128'({psel, penable}), 128'({exp_psel, exp_pen}));

            if (cpl_q.size() > 0 && cpl_q[0].cyc < cyc) begin
                checkOutput("cpl_missing", 128'(cyc), 128'(cpl_q[0].cyc));
                void'(cpl_q.pop_front());
            end
            if (wready || rvalid) begin
                if (cpl_q.size() == 0) begin
                    checkOutput("cpl_unexpected", 128'({wready, rvalid}), 128'(0));
                end else begin
                    mon_c = cpl_q.pop_front();
                    checkOutput("completion", 128'({cyc, wready, rvalid, slverr}),
                                128'({mon_c.cyc, mon_c.w, !mon_c.w, mon_c.err}));
                    if (!mon_c.w) exp_rdata = mon_c.rdata;
                end
            end
            checkOutput("rdata", 128'(rdata), 128'(exp_rdata));

            if (apb_q.size() > 0 && apb_q[0].cyc < cyc) begin
                checkOutput("setup_missing", 128'(cyc), 128'(apb_q[0].cyc));
                void'(apb_q.pop_front());
            end
            if (psel && !penable) begin
                if (apb_q.size() == 0) begin
                    checkOutput("setup_unexpected", 128'(psel), 128'(0));
                end else begin
                    mon_cur = apb_q.pop_front();
                    checkOutput("apb_setup", 128'({cyc, pwrite, paddr, pwdata, pstrb}),
                                128'({mon_cur.cyc, mon_cur.w, mon_cur.addr, mon_cur.data, mon_cur.strb}));
                end
            end else if (psel && penable) begin
                checkOutput("apb_access", 128'({pwrite, paddr, pwdata, pstrb}),
                            128'({mon_cur.w, mon_cur.addr, mon_cur.data, mon_cur.strb}));
            end

            while (ovf_q.size() > 0 && ovf_q[0] < cyc) begin
                checkOutput("ovf_missing", 128'(cyc), 128'(ovf_q[0]));
                void'(ovf_q.pop_front());
            end
            if (ovf || (ovf_q.size() > 0 && ovf_q[0] == cyc)) begin
                checkOutput("ovf", 128'(ovf), 128'(ovf_q.size() > 0 && ovf_q[0] == cyc));
                if (ovf_q.size() > 0 && ovf_q[0] == cyc) void'(ovf_q.pop_front());
            end
        end
    end

    initial begin
        #1 rstn = 1'b0;
        #2;
        checkOutput("reset_apb", 128'({psel, penable, pwrite, paddr, pwdata, pstrb}), 128'(0));
        checkOutput("reset_lb", 128'({wready, rvalid, slverr, ovf, rdata}), 128'(0));
        repeat (3) @(negedge clk);
        rstn   = 1'b1;
        mon_en = 1'b1;
        idle_cycles(2);

        // Zero-wait write, then a read with two wait states and known data.
        f_waits = 0; f_err = 0;
        applyStimulus(1'b1, 16'h0004, 32'hdeadbeef, 4'hf, 1'b0, 16'h0);
        idle_cycles(4);
        f_waits = 2; f_data_en = 1'b1; f_data = 32'h00ffff00;
        applyStimulus(1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 16'h0000);
        idle_cycles(6);
        f_data_en = 1'b0;

        // Simultaneous write and read; then an errored write with a second write that must overflow.
        f_waits = 0;
        applyStimulus(1'b1, 16'h0010, 32'h12345678, 4'h3, 1'b1, 16'h0020);
        idle_cycles(6);
        f_err = 1;
        applyStimulus(1'b1, 16'h0030, 32'hcafef00d, 4'hf, 1'b0, 16'h0);
        applyStimulus(1'b1, 16'h0034, 32'h0badf00d, 4'hf, 1'b0, 16'h0);
        idle_cycles(5);

        // Completer never answers: the watchdog must end the read.
        f_waits = 20; f_err = -1;
        applyStimulus(1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 16'h0044);
        idle_cycles(14);

        f_waits = -1;
        for (int i = 0; i < 800; i++) begin
            applyStimulus(1'($urandom_range(0, 3) == 0), 16'($urandom), $urandom, 4'($urandom),
                          1'($urandom_range(0, 3) == 0), 16'($urandom));
        end
        idle_cycles(20);

        // Reset while a read sits in ACCESS.
        f_waits = 20;
        applyStimulus(1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 16'h0050);
        idle_cycles(3);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        checkOutput("reset_mid_psel", 128'({psel, penable}), 128'(0));
        checkOutput("reset_mid_lb", 128'({wready, rvalid, slverr, ovf, rdata, paddr}), 128'(0));
        clear_model();
        f_waits = -1;
        @(negedge clk);
        rstn = 1'b1;
        idle_cycles(20);

        checkOutput("drain_cpl", 128'(cpl_q.size()), 128'(0));
        checkOutput("drain_apb", 128'(apb_q.size()), 128'(0));
        checkOutput("drain_ovf", 128'(ovf_q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
